matmul_sequencer: RTL and testbench

Sequential controller for the matrix-multiply datapath. It holds operand matrices A (ROWS1×COLS1) and B (COLS1×COLS2) in local register buffers and runs one multiply-accumulate per cycle over the i/j/k loop nest. Each C element is streamed out over a valid/ready handshake. It replaces the fully unrolled combinational multiplier where area matters, trading latency for a single multiplier.

---
 rtl/matmul_sequencer_if.sv | 41 ++++
 rtl/matmul_sequencer.sv | 171 +++++++++++++++++
 tb/tb_matmul_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_sequencer_if.sv
// Bus bundle for matmul_sequencer: operand buffer writes, run control and the C result stream.
// The master side (producer/consumer) drives writes, start and c_ready; the sequencer is the slave.
interface matmul_sequencer_if #(
    parameter int ROWS1 = 2,
    parameter int COLS1 = 2,
    parameter int COLS2 = 2,
    parameter int DW    = 16,
    parameter int ACCW  = 32
);
    localparam int AAW = (ROWS1 * COLS1 > 1) ? $clog2(ROWS1 * COLS1) : 1;
    localparam int BAW = (COLS1 * COLS2 > 1) ? $clog2(COLS1 * COLS2) : 1;
    localparam int CAW = (ROWS1 * COLS2 > 1) ? $clog2(ROWS1 * COLS2) : 1;

    logic            a_wr_en;
    logic [AAW-1:0]  a_wr_addr;
    logic [DW-1:0]   a_wr_data;
    logic            b_wr_en;
    logic [BAW-1:0]  b_wr_addr;
    logic [DW-1:0]   b_wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            c_valid;
    logic            c_ready;
    logic [ACCW-1:0] c_data;
    logic [CAW-1:0]  c_index;

    modport master (
        output a_wr_en, a_wr_addr, a_wr_data,
        output b_wr_en, b_wr_addr, b_wr_data,
        output start, c_ready,
        input  busy, done, c_valid, c_data, c_index
    );

    modport slave (
        input  a_wr_en, a_wr_addr, a_wr_data,
        input  b_wr_en, b_wr_addr, b_wr_data,
        input  start, c_ready,
        output busy, done, c_valid, c_data, c_index
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Single-multiplier matrix-multiply sequencer: C = A x B, one MAC per cycle, C streamed over valid/ready.
// Build option MATMUL_SAT_EN: accumulator saturates at 2^ACCW-1 instead of wrapping.
module matmul_sequencer #(
    parameter int ROWS1 = 2,
    parameter int COLS1 = 2,
    parameter int COLS2 = 2,
    parameter int DW    = 16,
    parameter int ACCW  = 32
) (
    input  logic               clk,
    input  logic               rst,
    matmul_sequencer_if.slave  bus
);
    localparam int AN  = ROWS1 * COLS1;
    localparam int BN  = COLS1 * COLS2;
    localparam int AAW = (AN > 1) ? $clog2(AN) : 1;
    localparam int BAW = (BN > 1) ? $clog2(BN) : 1;
    localparam int CAW = (ROWS1 * COLS2 > 1) ? $clog2(ROWS1 * COLS2) : 1;
    localparam int IW  = (ROWS1 > 1) ? $clog2(ROWS1) : 1;
    localparam int JW  = (COLS1 > 1) ? $clog2(COLS1) : 1;
    localparam int KW  = (COLS2 > 1) ? $clog2(COLS2) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   a_mem_r [AN];
    logic [DW-1:0]   b_mem_r [BN];
    logic [IW-1:0]   i_r;
    logic [JW-1:0]   j_r;
    logic [KW-1:0]   k_r;
    logic [ACCW-1:0] acc_r;
    logic            busy_r;
    logic            done_r;
    logic            c_valid_r;
    logic [ACCW-1:0] c_data_r;
    logic [CAW-1:0]  c_index_r;

    logic [AAW-1:0]  a_idx_s;
    logic [BAW-1:0]  b_idx_s;
    logic [CAW-1:0]  c_idx_s;
    logic [2*DW-1:0] prod_s;
    logic [ACCW-1:0] acc_next_s;
    logic            a_wr_ok_s;
    logic            b_wr_ok_s;
`ifdef MATMUL_SAT_EN
    logic [ACCW:0]   sum_s;
`else
    logic [ACCW-1:0] sum_s;
`endif

    // Out-of-range addresses are dropped; non-power-of-two buffers leave unused codes
    assign a_wr_ok_s = bus.a_wr_en && (int'(bus.a_wr_addr) < AN) && (state_r == S_IDLE);
    assign b_wr_ok_s = bus.b_wr_en && (int'(bus.b_wr_addr) < BN) && (state_r == S_IDLE);

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.c_valid = c_valid_r;
    assign bus.c_data  = c_data_r;
    assign bus.c_index = c_index_r;

    // Operand buffers: loaded only in IDLE and deliberately kept across reset
    always_ff @(posedge clk) begin
        if (a_wr_ok_s) begin
            a_mem_r[bus.a_wr_addr] <= bus.a_wr_data;
        end
        if (b_wr_ok_s) begin
            b_mem_r[bus.b_wr_addr] <= bus.b_wr_data;
        end
    end

    // MAC datapath: operand fetch, product and next accumulator value
    always_comb begin
        a_idx_s = AAW'(int'(i_r) * COLS1 + int'(j_r));
        b_idx_s = BAW'(int'(j_r) * COLS2 + int'(k_r));
        c_idx_s = CAW'(int'(i_r) * COLS2 + int'(k_r));
        prod_s  = {{DW{1'b0}}, a_mem_r[a_idx_s]} * {{DW{1'b0}}, b_mem_r[b_idx_s]};
`ifdef MATMUL_SAT_EN
        sum_s = {1'b0, acc_r} + (ACCW+1)'(prod_s);
        if (sum_s[ACCW]) begin
            acc_next_s = {ACCW{1'b1}};
        end else begin
            acc_next_s = sum_s[ACCW-1:0];
        end
`else
        sum_s      = acc_r + ACCW'(prod_s);
        acc_next_s = sum_s;
`endif
    end

    // Sequencer FSM with loop counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            i_r       <= '0;
            j_r       <= '0;
            k_r       <= '0;
            acc_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            c_valid_r <= 1'b0;
            c_data_r  <= '0;
            c_index_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        i_r     <= '0;
                        j_r     <= '0;
                        k_r     <= '0;
                        acc_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= S_MAC;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_MAC: begin
                    acc_r <= acc_next_s;
                    if (int'(j_r) == COLS1 - 1) begin
                        c_data_r  <= acc_next_s;
                        c_index_r <= c_idx_s;
                        c_valid_r <= 1'b1;
                        state_r   <= S_OUT;
                    end else begin
                        j_r <= j_r + JW'(1'b1);
                    end
                end
                S_OUT: begin
                    if (bus.c_ready) begin
                        c_valid_r <= 1'b0;
                        acc_r     <= '0;
                        j_r       <= '0;
                        if (int'(k_r) == COLS2 - 1) begin
                            k_r <= '0;
                            if (int'(i_r) == ROWS1 - 1) begin
                                i_r     <= '0;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= S_DONE;
                            end else begin
                                i_r     <= i_r + IW'(1'b1);
                                state_r <= S_MAC;
                            end
                        end else begin
                            k_r     <= k_r + KW'(1'b1);
                            state_r <= S_MAC;
                        end
                    end else begin
                        state_r <= S_OUT;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    c_valid_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a 2x2x2 instance (directed + random runs) and a 2x3x1 non-square instance,
// checked against plain-arithmetic matrix products.
module tb_matmul_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Cycle counter used to measure latencies relative to start
    always @(posedge clk) cyc <= cyc + 1;

    matmul_sequencer_if #(.ROWS1(2), .COLS1(2), .COLS2(2), .DW(16), .ACCW(32)) m0 ();
    matmul_sequencer_if #(.ROWS1(2), .COLS1(3), .COLS2(1), .DW(16), .ACCW(32)) m1 ();

    matmul_sequencer #(.ROWS1(2), .COLS1(2), .COLS2(2), .DW(16), .ACCW(32)) dut0 (
        .clk(clk), .rst(rst), .bus(m0)
    );
    matmul_sequencer #(.ROWS1(2), .COLS1(3), .COLS2(1), .DW(16), .ACCW(32)) dut1 (
        .clk(clk), .rst(rst), .bus(m1)
    );

    logic [15:0] ra [4];
    logic [15:0] rb [4];
    logic [31:0] expc [4];
    logic [15:0] ra1 [6];
    logic [15:0] rb1 [3];
    logic [31:0] expc1 [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference C element: plain dot product, then wrap or clamp to 32 bits
    function automatic logic [31:0] clamp32(input longint s);
        longint r;
        r = s;
`ifdef MATMUL_SAT_EN
        if (r > 64'h0000_0000_FFFF_FFFF) r = 64'h0000_0000_FFFF_FFFF;
`endif
        return r[31:0];
    endfunction

    function automatic logic [31:0] ref_c(input int i, input int k);
        longint s;
        s = 0;
        for (int j = 0; j < 2; j++) s += longint'(ra[i*2+j]) * longint'(rb[j*2+k]);
        return clamp32(s);
    endfunction

    function automatic logic [31:0] ref_c1(input int i);
        longint s;
        s = 0;
        for (int j = 0; j < 3; j++) s += longint'(ra1[i*3+j]) * longint'(rb1[j]);
        return clamp32(s);
    endfunction

    task automatic load0();
        for (int n = 0; n < 4; n++) begin
            m0.a_wr_en = 1'b1; m0.a_wr_addr = 2'(n); m0.a_wr_data = ra[n];
            m0.b_wr_en = 1'b1; m0.b_wr_addr = 2'(n); m0.b_wr_data = rb[n];
            @(posedge clk); #1;
        end
        m0.a_wr_en = 1'b0;
        m0.b_wr_en = 1'b0;
    endtask

    task automatic load1();
        for (int n = 0; n < 6; n++) begin
            m1.a_wr_en = 1'b1; m1.a_wr_addr = 3'(n); m1.a_wr_data = ra1[n];
            m1.b_wr_en = (n < 3); m1.b_wr_addr = 2'(n % 3); m1.b_wr_data = rb1[n % 3];
            @(posedge clk); #1;
        end
        // Out-of-range writes that must leave the buffers untouched
        m1.a_wr_addr = 3'd6; m1.a_wr_data = 16'd50;
        m1.b_wr_en = 1'b1; m1.b_wr_addr = 2'd3; m1.b_wr_data = 16'd100;
        @(posedge clk); #1;
        m1.a_wr_addr = 3'd7; m1.b_wr_en = 1'b0;
        @(posedge clk); #1;
        m1.a_wr_en = 1'b0;
    endtask

    // One 2x2 run: stall = cycles of c_ready low per element, poke = start/write attempts while busy
    task automatic run0(input string nm, input int stall, input bit poke,
                        input bit late_wr, input logic [15:0] late_val, input int exp_done);
        int t0, got, wcnt, lat_first, lat_done;
        got = 0; wcnt = 0; lat_first = -1; lat_done = -1;
        m0.start = 1'b1;
        m0.b_wr_en = late_wr; m0.b_wr_addr = 2'd3; m0.b_wr_data = late_val;
        m0.c_ready = (stall == 0);
        t0 = cyc;
        @(posedge clk); #1;
        m0.start = 1'b0; m0.b_wr_en = 1'b0;
        for (int n = 1; n < 300 && lat_done < 0; n++) begin
            m0.start = 1'b0; m0.a_wr_en = 1'b0;
            if (m0.c_valid) begin
                if (lat_first < 0) lat_first = cyc - t0;
                if (got < 4) begin
                    check({nm, "_idx"}, m0.c_index, got);
                    check({nm, "_data"}, m0.c_data, expc[got]);
                end else begin
                    check({nm, "_extra_elem"}, got, 4);
                end
                if (wcnt < stall) begin
                    m0.c_ready = 1'b0; wcnt++;
                end else begin
                    m0.c_ready = 1'b1; got++; wcnt = 0;
                end
            end else begin
                m0.c_ready = (stall == 0);
            end
            if (m0.done) begin
                lat_done = cyc - t0;
                check({nm, "_busy_at_done"}, m0.busy, 0);
                check({nm, "_count"}, got, 4);
                if (poke) m0.start = 1'b1;
            end else begin
                check({nm, "_busy"}, m0.busy, 1);
            end
            if (poke && n >= 2 && n <= 4) begin
                m0.start = 1'b1;
                m0.a_wr_en = 1'b1; m0.a_wr_addr = 2'd0; m0.a_wr_data = 16'd9;
            end
            @(posedge clk); #1;
        end
        m0.start = 1'b0; m0.a_wr_en = 1'b0; m0.c_ready = 1'b1;
        check({nm, "_first_valid"}, lat_first, 3);
        check({nm, "_done_lat"}, lat_done, exp_done);
        check({nm, "_done_pulse"}, m0.done, 0);
        check({nm, "_idle_valid"}, m0.c_valid, 0);
        @(posedge clk); #1;
        check({nm, "_idle_busy"}, m0.busy, 0);
    endtask

    task automatic run1(input string nm);
        int t0, got, lat_first, lat_done;
        got = 0; lat_first = -1; lat_done = -1;
        m1.c_ready = 1'b1; m1.start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        m1.start = 1'b0;
        for (int n = 1; n < 100 && lat_done < 0; n++) begin
            if (m1.c_valid) begin
                if (lat_first < 0) lat_first = cyc - t0;
                if (got < 2) begin
                    check({nm, "_idx"}, m1.c_index, got);
                    check({nm, "_data"}, m1.c_data, expc1[got]);
                end else begin
                    check({nm, "_extra_elem"}, got, 2);
                end
                got++;
            end
            if (m1.done) lat_done = cyc - t0;
            @(posedge clk); #1;
        end
        check({nm, "_first_valid"}, lat_first, 4);
        check({nm, "_done_lat"}, lat_done, 9);
        check({nm, "_count"}, got, 2);
    endtask

    initial begin
        int t0, stall, seen;
        rst = 1'b1;
        m0.a_wr_en = 1'b0; m0.a_wr_addr = '0; m0.a_wr_data = '0;
        m0.b_wr_en = 1'b0; m0.b_wr_addr = '0; m0.b_wr_data = '0;
        m0.start = 1'b0; m0.c_ready = 1'b1;
        m1.a_wr_en = 1'b0; m1.a_wr_addr = '0; m1.a_wr_data = '0;
        m1.b_wr_en = 1'b0; m1.b_wr_addr = '0; m1.b_wr_data = '0;
        m1.start = 1'b0; m1.c_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", m0.busy, 0);
        check("rst_done", m0.done, 0);
        check("rst_valid", m0.c_valid, 0);
        check("rst_data", m0.c_data, 0);
        check("rst_index", m0.c_index, 0);
        check("rst_busy1", m1.busy, 0);

        // Basic 2x2 product, then with backpressure
        ra = '{16'd1, 16'd2, 16'd3, 16'd4};
        rb = '{16'd5, 16'd6, 16'd7, 16'd8};
        expc = '{32'd19, 32'd22, 32'd43, 32'd50};
        load0();
        run0("basic", 0, 1'b0, 1'b0, 16'd0, 13);
        run0("stall", 4, 1'b0, 1'b0, 16'd0, 29);

        // start and A writes while busy (and start in DONE) are ignored
        run0("guard", 0, 1'b1, 1'b0, 16'd0, 13);
        repeat (2) @(posedge clk);
        #1;
        check("guard_no_rerun", m0.busy, 0);
        run0("rerun", 0, 1'b0, 1'b0, 16'd0, 13);

        // Reset during the second MAC cycle aborts the run
        m0.start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        m0.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", m0.busy, 0);
        check("midrst_done", m0.done, 0);
        check("midrst_valid", m0.c_valid, 0);
        check("midrst_data", m0.c_data, 0);
        check("midrst_index", m0.c_index, 0);
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (m0.done || m0.c_valid || m0.busy) seen++;
            @(posedge clk); #1;
        end
        check("midrst_quiet", seen, 0);
        run0("after_rst", 0, 1'b0, 1'b0, 16'd0, 13);

        // Accumulator overflow
        ra = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        rb = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`ifdef MATMUL_SAT_EN
        expc = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`else
        expc = '{32'hFFFC_0002, 32'hFFFC_0002, 32'hFFFC_0002, 32'hFFFC_0002};
`endif
        load0();
        run0("ovf", 0, 1'b0, 1'b0, 16'd0, 13);

        // Random operands and stalls; odd runs also rewrite B[1][1] in the start cycle
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 4; n++) begin
                ra[n] = (r % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
                rb[n] = (r % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
            end
            load0();
            if (r % 2 == 1) rb[3] = 16'($urandom);
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 2; k++) expc[i*2+k] = ref_c(i, k);
            stall = $urandom_range(0, 3);
            run0("rand", stall, 1'b0, (r % 2 == 1), rb[3], 13 + 4 * stall);
        end

        // Non-square 2x3 * 3x1
        ra1 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        rb1 = '{16'd1, 16'd1, 16'd1};
        expc1 = '{32'd6, 32'd15};
        load1();
        run1("nsq");
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 6; n++) ra1[n] = 16'($urandom);
            for (int n = 0; n < 3; n++) rb1[n] = 16'($urandom);
            load1();
            for (int i = 0; i < 2; i++) expc1[i] = ref_c1(i);
            run1("nsq_rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
